// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/bubble controller for the five-stage pipeline.
// Resolves trap, memory-wait, multicycle, redirect and load-use hazards in a
// fixed priority order. It also tracks in-flight fetch requests so that
// responses from a flushed path are discarded instead of latched into regD.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_RUN  | no stale fetch responses pending; responses pass to regD
//   ST_DROP | r_drop_cnt stale responses still due; each one is discarded
module pipe_hazard_ctrl #(
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  dec_i_rs1,
  input  logic [4:0]  dec_i_rs2,
  input  logic        dec_i_rs1_en,
  input  logic        dec_i_rs2_en,
  input  logic [4:0]  exe_i_rd,
  input  logic        exe_i_load,
  input  logic        exe_i_redirect,
  input  logic        exe_i_mc_busy,
  input  logic        mem_i_req_valid,
  input  logic        mem_i_req_ready,
  input  logic        wb_i_trap,
  input  logic        if_i_req_fire,
  input  logic        if_i_resp_valid,
  output logic        regF_stall,
  output logic        regD_stall,
  output logic        regE_stall,
  output logic        regM_stall,
  output logic        regD_bubble,
  output logic        regE_bubble,
  output logic        regM_bubble,
  output logic        regW_bubble,
  output logic        ctrl_o_drop_resp,
  output logic [31:0] ctrl_o_stall_cycles
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic {ST_RUN, ST_DROP} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_out_cnt;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic [31:0]        r_stall_cycles;

  logic               w_mem_wait;
  logic               w_rs1_hit;
  logic               w_rs2_hit;
  logic               w_load_use;
  logic               w_f_stall;
  logic               w_d_stall;
  logic               w_e_stall;
  logic               w_m_stall;
  logic               w_d_bub;
  logic               w_e_bub;
  logic               w_m_bub;
  logic               w_w_bub;
  logic               w_flush;
  logic               w_drop;
  logic [CNT_W-1:0]   w_drop_load;
  logic [CNT_W-1:0]   w_out_cnt_nxt;

  assign w_mem_wait = mem_i_req_valid & ~mem_i_req_ready;

  // A load to x0 never produces a value, so it cannot cause a load-use stall.
  assign w_rs1_hit  = dec_i_rs1_en & (dec_i_rs1 == exe_i_rd);
  assign w_rs2_hit  = dec_i_rs2_en & (dec_i_rs2 == exe_i_rd);
  assign w_load_use = exe_i_load & (exe_i_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

  // Hazard priority: only the highest active condition drives its stall/bubble set.
  always_comb begin
    w_f_stall = 1'b0;
    w_d_stall = 1'b0;
    w_e_stall = 1'b0;
    w_m_stall = 1'b0;
    w_d_bub   = 1'b0;
    w_e_bub   = 1'b0;
    w_m_bub   = 1'b0;
    w_w_bub   = 1'b0;
    w_flush   = 1'b0;
    if (wb_i_trap) begin
      w_d_bub = 1'b1;
      w_e_bub = 1'b1;
      w_m_bub = 1'b1;
      w_w_bub = 1'b1;
      w_flush = 1'b1;
    end else if (w_mem_wait) begin
      w_f_stall = 1'b1;
      w_d_stall = 1'b1;
      w_e_stall = 1'b1;
      w_m_stall = 1'b1;
      w_w_bub   = 1'b1;
    end else if (exe_i_mc_busy) begin
      // A redirect raised under a busy multicycle op is held by E and
      // taken once the stall lifts, so it is ignored here.
      w_f_stall = 1'b1;
      w_d_stall = 1'b1;
      w_e_stall = 1'b1;
      w_m_bub   = 1'b1;
    end else if (exe_i_redirect) begin
      w_d_bub = 1'b1;
      w_e_bub = 1'b1;
      w_flush = 1'b1;
    end else if (w_load_use) begin
      w_f_stall = 1'b1;
      w_d_stall = 1'b1;
      w_e_bub   = 1'b1;
    end
  end

  // A response that arrives while stale responses are pending belongs to the old path.
  assign w_drop = (r_state == ST_DROP) & if_i_resp_valid;

  // A response arriving in the flush cycle is already dropped (or accepted)
  // this cycle, so it is not counted among the remaining stale responses.
  // A request fired in the flush cycle belongs to the new path and is excluded.
  assign w_drop_load = r_out_cnt - CNT_W'(if_i_resp_valid);

  // Outstanding fetch count for the next cycle; fire and response cancel out.
  always_comb begin
    w_out_cnt_nxt = r_out_cnt;
    case ({if_i_req_fire, if_i_resp_valid})
      2'b10:   w_out_cnt_nxt = r_out_cnt + CNT_W'(1);
      2'b01:   w_out_cnt_nxt = r_out_cnt - CNT_W'(1);
      default: w_out_cnt_nxt = r_out_cnt;
    endcase
  end

  // Drop FSM plus outstanding, drop and stall-cycle counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_RUN;
      r_out_cnt      <= '0;
      r_drop_cnt     <= '0;
      r_stall_cycles <= 32'd0;
    end else begin
      r_out_cnt <= w_out_cnt_nxt;
      if (w_flush) begin
        r_drop_cnt <= w_drop_load;
        r_state    <= (w_drop_load != '0) ? ST_DROP : ST_RUN;
      end else if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
        if (r_drop_cnt == CNT_W'(1)) begin
          r_state <= ST_RUN;
        end
      end
      if (w_f_stall) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  // While reset is held, every register is cleared and nothing is stalled,
  // independent of the clock.
  assign regF_stall  = rst & w_f_stall;
  assign regD_stall  = rst & w_d_stall;
  assign regE_stall  = rst & w_e_stall;
  assign regM_stall  = rst & w_m_stall;
  assign regD_bubble = ~rst | w_d_bub | w_drop;
  assign regE_bubble = ~rst | w_e_bub;
  assign regM_bubble = ~rst | w_m_bub;
  assign regW_bubble = ~rst | w_w_bub;

  assign ctrl_o_drop_resp    = rst & w_drop;
  assign ctrl_o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. The driver pushes hand-computed
// expectations per cycle; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  localparam int MAX_OUT = 2;

  logic        clk;
  logic        rst;
  logic [4:0]  dec_i_rs1, dec_i_rs2, exe_i_rd;
  logic        dec_i_rs1_en, dec_i_rs2_en;
  logic        exe_i_load, exe_i_redirect, exe_i_mc_busy;
  logic        mem_i_req_valid, mem_i_req_ready, wb_i_trap;
  logic        if_i_req_fire, if_i_resp_valid;
  logic        regF_stall, regD_stall, regE_stall, regM_stall;
  logic        regD_bubble, regE_bubble, regM_bubble, regW_bubble;
  logic        ctrl_o_drop_resp;
  logic [31:0] ctrl_o_stall_cycles;

  pipe_hazard_ctrl #(.MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .dec_i_rs1(dec_i_rs1), .dec_i_rs2(dec_i_rs2),
    .dec_i_rs1_en(dec_i_rs1_en), .dec_i_rs2_en(dec_i_rs2_en),
    .exe_i_rd(exe_i_rd), .exe_i_load(exe_i_load),
    .exe_i_redirect(exe_i_redirect), .exe_i_mc_busy(exe_i_mc_busy),
    .mem_i_req_valid(mem_i_req_valid), .mem_i_req_ready(mem_i_req_ready),
    .wb_i_trap(wb_i_trap),
    .if_i_req_fire(if_i_req_fire), .if_i_resp_valid(if_i_resp_valid),
    .regF_stall(regF_stall), .regD_stall(regD_stall),
    .regE_stall(regE_stall), .regM_stall(regM_stall),
    .regD_bubble(regD_bubble), .regE_bubble(regE_bubble),
    .regM_bubble(regM_bubble), .regW_bubble(regW_bubble),
    .ctrl_o_drop_resp(ctrl_o_drop_resp),
    .ctrl_o_stall_cycles(ctrl_o_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  st;   // F,D,E,M stall
    logic [3:0]  bu;   // D,E,M,W bubble
    logic        dr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          m_out  = 0;
  logic [31:0] acc    = 32'd0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Monitor: compares one expectation per cycle, away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.nm, " stall"},  {28'd0, regF_stall, regD_stall, regE_stall, regM_stall}, {28'd0, e.st});
      check({e.nm, " bubble"}, {28'd0, regD_bubble, regE_bubble, regM_bubble, regW_bubble}, {28'd0, e.bu});
      check({e.nm, " drop"},   {31'd0, ctrl_o_drop_resp}, {31'd0, e.dr});
      check({e.nm, " cnt"},    ctrl_o_stall_cycles, e.cnt);
    end
  end

  task automatic clr();
    dec_i_rs1 = 0; dec_i_rs2 = 0; exe_i_rd = 0;
    dec_i_rs1_en = 0; dec_i_rs2_en = 0;
    exe_i_load = 0; exe_i_redirect = 0; exe_i_mc_busy = 0;
    mem_i_req_valid = 0; mem_i_req_ready = 0; wb_i_trap = 0;
    if_i_req_fire = 0; if_i_resp_valid = 0;
  endtask

  // Issue the currently driven inputs for one cycle with their expected response.
  task automatic cyc(input string nm, input logic [3:0] st, input logic [3:0] bu, input logic dr);
    exp_t e;
    e.nm = nm; e.st = st; e.bu = bu; e.dr = dr; e.cnt = acc;
    q.push_back(e);
    if (st[3]) acc = acc + 32'd1;
    assert (!(if_i_req_fire && m_out == MAX_OUT && !if_i_resp_valid))
      else $error("protocol violation: fetch request with outstanding limit reached");
    assert (!(if_i_resp_valid && m_out == 0))
      else $error("protocol violation: fetch response with none outstanding");
    m_out = m_out + int'(if_i_req_fire) - int'(if_i_resp_valid);
    @(posedge clk); #1;
    clr();
  endtask

  initial begin
    clr();
    rst = 1'b0;
    mem_i_req_valid = 1; wb_i_trap = 1;
    @(posedge clk); @(posedge clk); #1;
    check("reset stall",  {28'd0, regF_stall, regD_stall, regE_stall, regM_stall}, 32'd0);
    check("reset bubble", {28'd0, regD_bubble, regE_bubble, regM_bubble, regW_bubble}, 32'hF);
    check("reset drop",   {31'd0, ctrl_o_drop_resp}, 32'd0);
    check("reset cnt",    ctrl_o_stall_cycles, 32'd0);
    clr();
    rst = 1'b1;
    @(posedge clk); #1;

    cyc("idle", 4'b0000, 4'b0000, 0);

    exe_i_load = 1; exe_i_rd = 5; dec_i_rs1_en = 1; dec_i_rs1 = 5;
    cyc("lu rs1", 4'b1100, 4'b0100, 0);
    cyc("lu after", 4'b0000, 4'b0000, 0);
    exe_i_load = 1; exe_i_rd = 0; dec_i_rs1_en = 1; dec_i_rs1 = 0;
    cyc("lu x0", 4'b0000, 4'b0000, 0);
    exe_i_load = 1; exe_i_rd = 7; dec_i_rs2_en = 1; dec_i_rs2 = 7;
    cyc("lu rs2", 4'b1100, 4'b0100, 0);
    exe_i_load = 1; exe_i_rd = 7; dec_i_rs2 = 7; dec_i_rs1 = 7;
    cyc("lu no en", 4'b0000, 4'b0000, 0);

    for (int i = 0; i < 3; i++) begin
      mem_i_req_valid = 1; mem_i_req_ready = 0; exe_i_redirect = 1;
      cyc("memwait", 4'b1111, 4'b0001, 0);
    end
    mem_i_req_valid = 1; mem_i_req_ready = 1; exe_i_redirect = 1;
    cyc("mem ready", 4'b0000, 4'b1100, 0);
    exe_i_mc_busy = 1; exe_i_redirect = 1;
    cyc("mc busy", 4'b1110, 4'b0010, 0);
    wb_i_trap = 1; mem_i_req_valid = 1; exe_i_mc_busy = 1;
    cyc("trap prio", 4'b0000, 4'b1111, 0);
    cyc("cnt after", 4'b0000, 4'b0000, 0);

    // Redirect with two outstanding, no response that cycle.
    if_i_req_fire = 1; cyc("fire a", 4'b0000, 4'b0000, 0);
    if_i_req_fire = 1; cyc("fire b", 4'b0000, 4'b0000, 0);
    exe_i_redirect = 1; cyc("redir2", 4'b0000, 4'b1100, 0);
    cyc("drop idle", 4'b0000, 4'b0000, 0);
    if_i_resp_valid = 1; cyc("drop 1", 4'b0000, 4'b1000, 1);
    if_i_resp_valid = 1; cyc("drop 2", 4'b0000, 4'b1000, 1);
    if_i_req_fire = 1; cyc("fire c", 4'b0000, 4'b0000, 0);
    if_i_resp_valid = 1; cyc("keep 3", 4'b0000, 4'b0000, 0);

    // Redirect coincident with a response.
    if_i_req_fire = 1; cyc("fire d", 4'b0000, 4'b0000, 0);
    if_i_req_fire = 1; cyc("fire e", 4'b0000, 4'b0000, 0);
    exe_i_redirect = 1; if_i_resp_valid = 1;
    cyc("redir+resp", 4'b0000, 4'b1100, 0);
    if_i_resp_valid = 1; cyc("drop one", 4'b0000, 4'b1000, 1);
    if_i_req_fire = 1; cyc("fire f", 4'b0000, 4'b0000, 0);
    if_i_resp_valid = 1; cyc("keep f", 4'b0000, 4'b0000, 0);

    // Trap in DROP with one outstanding and a new fetch fired.
    if_i_req_fire = 1; cyc("fire g", 4'b0000, 4'b0000, 0);
    if_i_req_fire = 1; cyc("fire h", 4'b0000, 4'b0000, 0);
    exe_i_redirect = 1; cyc("redir3", 4'b0000, 4'b1100, 0);
    if_i_resp_valid = 1; cyc("drop g", 4'b0000, 4'b1000, 1);
    wb_i_trap = 1; if_i_req_fire = 1;
    cyc("trap drop", 4'b0000, 4'b1111, 0);
    if_i_resp_valid = 1; cyc("drop h", 4'b0000, 4'b1000, 1);
    if_i_resp_valid = 1; cyc("post trap", 4'b0000, 4'b0000, 0);

    // Async reset in the middle of DROP.
    if_i_req_fire = 1; cyc("fire i", 4'b0000, 4'b0000, 0);
    if_i_req_fire = 1; cyc("fire j", 4'b0000, 4'b0000, 0);
    exe_i_redirect = 1; cyc("redir4", 4'b0000, 4'b1100, 0);
    mem_i_req_valid = 1; if_i_resp_valid = 1;
    #2 rst = 1'b0;
    #1;
    check("arst stall",  {28'd0, regF_stall, regD_stall, regE_stall, regM_stall}, 32'd0);
    check("arst bubble", {28'd0, regD_bubble, regE_bubble, regM_bubble, regW_bubble}, 32'hF);
    check("arst drop",   {31'd0, ctrl_o_drop_resp}, 32'd0);
    check("arst cnt",    ctrl_o_stall_cycles, 32'd0);
    clr();
    @(posedge clk); #1;
    rst = 1'b1; m_out = 0; acc = 32'd0;
    cyc("post rst", 4'b0000, 4'b0000, 0);
    if_i_req_fire = 1; cyc("fire k", 4'b0000, 4'b0000, 0);
    if_i_resp_valid = 1; cyc("keep k", 4'b0000, 4'b0000, 0);
    mem_i_req_valid = 1; cyc("mw again", 4'b1111, 4'b0001, 0);
    cyc("cnt one", 4'b0000, 4'b0000, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
